// File: rtl/pipe_adder_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
package pipe_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    // Width of one carry-chain slice
    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// One registered carry-chain slice: sum and carry-out held on enable.
module pipe_adder_slice
    import pipe_adder_pkg::*;
#(
    parameter int SW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout
);

    logic [SW:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (en) begin
            sum  <= full[SW-1:0];
            cout <= full[SW];
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined unsigned add/sub with valid/ready flow control and overflow counter.
// Define PIPE_ADDER_SAT_EN to clamp the result on overflow.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STAGES    = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     value_a,
    input  logic [WIDTH-1:0]     value_b,
    input  logic                 op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     sum,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] ovf_count,
    input  logic                 ovf_clear
);

    localparam int SW = slice_w(WIDTH, STAGES);

    logic                                adv;
    logic [STAGES:1]                     vld_pipe;
    logic [STAGES:1]                     op_pipe;
    logic [STAGES:1][WIDTH-1:0]          a_pipe;
    logic [STAGES:1][WIDTH-1:0]          b_pipe;
    logic [STAGES:1][STAGES-1:0][SW-1:0] res_pipe;

    // Stage sources: index 0 is the input port, index k the stage-k register
    logic [STAGES:0][WIDTH-1:0] a_src;
    logic [STAGES:0][WIDTH-1:0] b_src;
    logic [STAGES:0]            op_src;

    logic [STAGES-1:0][SW-1:0]  sum_sl;
    logic [STAGES-1:0]          cout_sl;
    logic [STAGES-1:0]          cin_sl;
    logic [WIDTH-1:0]           raw;

    assign out_valid = vld_pipe[STAGES];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    always_comb begin
        a_src     = '0;
        b_src     = '0;
        op_src    = '0;
        a_src[0]  = value_a;
        b_src[0]  = value_b;
        op_src[0] = op;
        for (int k = 1; k <= STAGES; k++) begin
            a_src[k]  = a_pipe[k];
            b_src[k]  = b_pipe[k];
            op_src[k] = op_pipe[k];
        end
    end

    // The +1 of A + ~B + 1 enters as carry-in of the lowest slice
    always_comb begin
        cin_sl    = '0;
        cin_sl[0] = op_src[0];
        for (int k = 1; k < STAGES; k++)
            cin_sl[k] = cout_sl[k-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            op_pipe  <= '0;
            a_pipe   <= '0;
            b_pipe   <= '0;
            res_pipe <= '0;
        end else if (adv) begin
            vld_pipe[1] <= in_valid;
            for (int k = 1; k <= STAGES; k++) begin
                a_pipe[k]  <= a_src[k-1];
                b_pipe[k]  <= b_src[k-1];
                op_pipe[k] <= op_src[k-1];
            end
            for (int k = 2; k <= STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                for (int j = 0; j < STAGES; j++)
                    res_pipe[k][j] <= (j == k - 2) ? sum_sl[j] : res_pipe[k-1][j];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        pipe_adder_slice #(.SW(SW)) u_slice (
            .clk  (clk),
            .rst  (rst),
            .en   (adv),
            .a    (a_src[k][k*SW +: SW]),
            .b    (b_src[k][k*SW +: SW] ^ {SW{op_src[k]}}),
            .cin  (cin_sl[k]),
            .sum  (sum_sl[k]),
            .cout (cout_sl[k])
        );
    end

    // Top slice comes straight from its register; lower slices from the delay lines
    always_comb begin
        raw = '0;
        for (int j = 0; j < STAGES; j++)
            raw[j*SW +: SW] = (j == STAGES - 1) ? sum_sl[j] : res_pipe[STAGES][j];
    end

    assign overflow = cout_sl[STAGES-1] ^ op_pipe[STAGES];

`ifdef PIPE_ADDER_SAT_EN
    assign sum = !overflow ? raw :
                 (op_t'(op_pipe[STAGES]) == OP_SUB) ? '0 : '1;
`else
    assign sum = raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_count <= '0;
        else if (ovf_clear)
            ovf_count <= '0;
        else if (out_valid && out_ready && overflow && (ovf_count != '1))
            ovf_count <= ovf_count + 1'b1;
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=8, STAGES=2, CNT_WIDTH=2).
module tb_pipe_adder;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int CW = 2;
`ifdef PIPE_ADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  value_a = '0;
    logic [W-1:0]  value_b = '0;
    logic          op = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  sum;
    logic          overflow;
    logic [CW-1:0] ovf_count;
    logic          ovf_clear = 1'b0;

    pipe_adder #(.WIDTH(W), .STAGES(S), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .value_a   (value_a),
        .value_b   (value_b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .overflow  (overflow),
        .ovf_count (ovf_count),
        .ovf_clear (ovf_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         o;
        int           c;
    } exp_t;

    exp_t         sb[$];
    int           tests = 0;
    int           fails = 0;
    int           cycle = 0;
    int           cnt   = 0;
    bit           lat_chk = 1'b0;
    logic [W-1:0] last_sum = '0;
    logic         last_ovf = 1'b0;
    logic [W-1:0] s0;
    logic         o0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic o, input int c);
        exp_t e;
        int   full;
        if (!o) begin
            full = int'(a) + int'(b);
            e.o  = (full > (1 << W) - 1);
        end else begin
            full = int'(a) - int'(b);
            e.o  = (a < b);
        end
        e.s = full[W-1:0];
        if (SAT && e.o)
            e.s = o ? '0 : W'((1 << W) - 1);
        e.c = c;
        return e;
    endfunction

    task automatic cyc();
        bit   acc, dlv, eo;
        exp_t e;
        #1;
        acc = in_valid && in_ready;
        dlv = out_valid && out_ready;
        eo  = 1'b0;
        if (dlv) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 0);
            end else begin
                e  = sb.pop_front();
                eo = e.o;
                chk("sum", 32'(sum), 32'(e.s));
                chk("ovf", 32'(overflow), 32'(e.o));
                if (lat_chk) chk("latency", cycle - e.c, S);
                last_sum = sum;
                last_ovf = overflow;
            end
        end
        if (acc) sb.push_back(model(value_a, value_b, op, cycle));
        if (ovf_clear) cnt = 0;
        else if (dlv && eo && cnt < (1 << CW) - 1) cnt++;
        @(posedge clk);
        #1;
        cycle++;
        chk("ovf_count", 32'(ovf_count), cnt);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 10) begin
            cyc();
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
        value_a   = a;
        value_b   = b;
        op        = o;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        drain();
    endtask

    initial begin
        int n;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_ovf_count", 32'(ovf_count), 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);

        // Directed add/sub cases
        run_op(8'd200, 8'd100, 1'b0);
        chk("add_sum", 32'(last_sum), SAT ? 255 : 44);
        chk("add_ovf", 32'(last_ovf), 1);
        chk("add_cnt", 32'(ovf_count), 1);
        run_op(8'd5, 8'd7, 1'b1);
        chk("sub57_sum", 32'(last_sum), SAT ? 0 : 254);
        chk("sub57_ovf", 32'(last_ovf), 1);
        run_op(8'd7, 8'd5, 1'b1);
        chk("sub75_sum", 32'(last_sum), 2);
        chk("sub75_ovf", 32'(last_ovf), 0);

        // Back-to-back random stream, fixed latency
        lat_chk = 1'b1;
        for (int i = 0; i < 20; i++) begin
            value_a  = W'($urandom);
            value_b  = W'($urandom);
            op       = 1'($urandom);
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        drain();
        lat_chk = 1'b0;

        // Backpressure with a full pipe
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            value_a = W'($urandom);
            value_b = W'($urandom);
            op      = 1'($urandom);
            cyc();
        end
        out_ready = 1'b0;
        #1;
        chk("stall_full", 32'(out_valid), 1);
        s0 = sum;
        o0 = overflow;
        for (int i = 0; i < 3; i++) begin
            value_a = W'($urandom);
            value_b = W'($urandom);
            op      = 1'($urandom);
            chk("stall_in_ready", 32'(in_ready), 0);
            cyc();
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_sum", 32'(sum), 32'(s0));
            chk("stall_ovf", 32'(overflow), 32'(o0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Counter clear, saturation, clear vs. increment
        ovf_clear = 1'b1;
        cyc();
        ovf_clear = 1'b0;
        chk("clr_cnt", 32'(ovf_count), 0);
        for (int i = 0; i < 5; i++) run_op(8'd200, 8'd100, 1'b0);
        chk("cnt_sat", 32'(ovf_count), 3);
        value_a  = 8'd250;
        value_b  = 8'd10;
        op       = 1'b0;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            cyc();
            n++;
        end
        chk("coinc_valid", 32'(out_valid), 1);
        ovf_clear = 1'b1;
        cyc();
        ovf_clear = 1'b0;
        chk("coinc_clr", 32'(ovf_count), 0);
        drain();

        // Reset with two results in flight
        run_op(8'd200, 8'd100, 1'b0);
        value_a  = 8'd255;
        value_b  = 8'd255;
        op       = 1'b0;
        in_valid = 1'b1;
        cyc();
        cyc();
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_cnt", 32'(ovf_count), 0);
        sb.delete();
        cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("post_rst_valid", 32'(out_valid), 0);
        chk("post_rst_ready", 32'(in_ready), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
